// File: rtl/fetch_queue_pkg.sv
// Shared widths and payload types for the fetch stage and its consumers.
package fetch_queue_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned FQ_DEPTH   = 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [INST_WIDTH-1:0] inst_t;

  // One queued fetch: the instruction word and the address it came from.
  typedef struct packed {
    inst_t inst;
    addr_t addr;
  } fq_entry_t;

  // Decode never consumes more than two entries per cycle; 3 behaves as 2.
  function automatic logic [1:0] clamp_issue(input logic [1:0] n);
    return (n == 2'd3) ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction memory, branch redirect and decode handshake.
interface fetch_queue_if
  #(parameter int unsigned DEPTH = fetch_queue_pkg::FQ_DEPTH);

  import fetch_queue_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  addr_t          pc;
  inst_t          instruction0;
  inst_t          instruction1;
  logic           branch_taken;
  addr_t          branch_target;
  logic [1:0]     issue_count;
  logic           out_valid0;
  logic           out_valid1;
  inst_t          out_inst0;
  inst_t          out_inst1;
  addr_t          out_pc0;
  addr_t          out_pc1;
  logic [CW-1:0]  count;

  // The fetch queue itself.
  modport master (
    output pc,
    input  instruction0, instruction1,
    input  branch_taken, branch_target,
    input  issue_count,
    output out_valid0, out_valid1,
    output out_inst0, out_inst1,
    output out_pc0, out_pc1,
    output count
  );

  // Memory, branch unit and decode surrounding the queue.
  modport slave (
    input  pc,
    output instruction0, instruction1,
    output branch_taken, branch_target,
    output issue_count,
    input  out_valid0, out_valid1,
    input  out_inst0, out_inst1,
    input  out_pc0, out_pc1,
    input  count
  );

endinterface

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch queue: paired write at tail, paired read at head.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_ptr,
  input  fq_entry_t     wr_data0,
  input  fq_entry_t     wr_data1,
  input  logic [PW-1:0] rd_ptr,
  output fq_entry_t     rd_data0,
  output fq_entry_t     rd_data1
);

  fq_entry_t mem [DEPTH];

  // Data carries no reset; occupancy is tracked by the owner.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr]           <= wr_data0;
      mem[wr_ptr + PW'(1)]  <= wr_data1;
    end
  end

  // Head and head+1 are always presented; validity is qualified upstream.
  always_comb begin
    rd_data0 = mem[rd_ptr];
    rd_data1 = mem[rd_ptr + PW'(1)];
  end

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue fetch: owns the PC, captures instruction pairs, feeds decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned           DEPTH    = FQ_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;
  addr_t         pc_q;

  logic [CW-1:0] issue_c;
  logic [CW-1:0] pop_c;
  logic [CW-1:0] count_after_pop_c;
  logic          push_c;
  logic          wr_en_c;
  fq_entry_t     wr_data0_c;
  fq_entry_t     wr_data1_c;
  fq_entry_t     rd_data0;
  fq_entry_t     rd_data1;

  // Pop is limited by occupancy; room for a pair is judged after the pop.
  always_comb begin
    issue_c           = CW'(clamp_issue(bus.issue_count));
    pop_c             = (issue_c < count_q) ? issue_c : count_q;
    count_after_pop_c = count_q - pop_c;
    push_c            = (count_after_pop_c <= CW'(DEPTH - 2));
    wr_en_c           = push_c && !bus.branch_taken;
    wr_data0_c        = '{inst: bus.instruction0, addr: pc_q};
    wr_data1_c        = '{inst: bus.instruction1, addr: pc_q + ADDR_WIDTH'(1)};
  end

  // Pointer, occupancy and PC update; a redirect overrides push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
    end else if (bus.branch_taken) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      pc_q    <= bus.branch_target;
    end else begin
      head <= head + PW'(pop_c);
      if (push_c) begin
        tail    <= tail + PW'(2);
        pc_q    <= pc_q + ADDR_WIDTH'(2);
        count_q <= count_after_pop_c + CW'(2);
      end else begin
        count_q <= count_after_pop_c;
      end
    end
  end

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk      (clk),
    .wr_en    (wr_en_c),
    .wr_ptr   (tail),
    .wr_data0 (wr_data0_c),
    .wr_data1 (wr_data1_c),
    .rd_ptr   (head),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1)
  );

  // Decode-facing view derived directly from registered state.
  always_comb begin
    bus.pc         = pc_q;
    bus.count      = count_q;
    bus.out_valid0 = (count_q >= CW'(1));
    bus.out_valid1 = (count_q >= CW'(2));
    bus.out_inst0  = rd_data0.inst;
    bus.out_pc0    = rd_data0.addr;
    bus.out_inst1  = rd_data1.inst;
    bus.out_pc1    = rd_data1.addr;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam addr_t       RESET_PC = 16'h0000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  function automatic inst_t imem_word(input addr_t a);
    return {16'hA5C3, a};
  endfunction

  // Instruction memory returns a word derived from its address.
  assign bus.instruction0 = imem_word(bus.pc);
  assign bus.instruction1 = imem_word(bus.pc + 16'd1);

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  fq_entry_t mq[$];
  addr_t     mpc;

  // Reference: consume from the front, then fetch a pair if it fits.
  task automatic model_edge(input logic [1:0] ic, input logic bt, input addr_t tgt);
    int take;
    if (bt) begin
      mq.delete();
      mpc = tgt;
    end else begin
      take = (ic == 2'd3) ? 2 : int'(ic);
      if (take > mq.size()) take = mq.size();
      repeat (take) void'(mq.pop_front());
      if (mq.size() + 2 <= int'(DEPTH)) begin
        mq.push_back('{inst: imem_word(mpc), addr: mpc});
        mq.push_back('{inst: imem_word(mpc + 16'd1), addr: mpc + 16'd1});
        mpc = mpc + 16'd2;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic step(input logic [1:0] ic, input logic bt, input addr_t tgt);
    bus.issue_count   = ic;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    @(posedge clk);
    model_edge(ic, bt, tgt);
    #1;
    bus.issue_count  = 2'd0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.issue_count = 2'd0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    #3;
    n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.out_valid0 !== 1'b0 || bus.out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b%b exp 00", bus.out_valid0, bus.out_valid1); end
    n_checks++; if (bus.pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", bus.pc, RESET_PC); end
    mq.delete();
    mpc = RESET_PC;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fill_idle();
    int exp;
    for (int i = 0; i < 5; i++) begin
      step(2'd0, 1'b0, '0);
      exp = (i < 4) ? 2 * (i + 1) : 8;
      n_checks++; if (bus.count !== CW'(exp)) begin n_fail++; $display("FAIL fill_count cyc %0d got %0d exp %0d", i, bus.count, exp); end
      n_checks++; if (bus.pc !== addr_t'(exp)) begin n_fail++; $display("FAIL fill_pc cyc %0d got %h exp %h", i, bus.pc, exp); end
    end
    n_checks++;
    if (bus.out_valid0 !== 1'b1 || bus.out_valid1 !== 1'b1 || bus.out_pc0 !== 16'h0000 || bus.out_pc1 !== 16'h0001
        || bus.out_inst0 !== 32'hA5C3_0000 || bus.out_inst1 !== 32'hA5C3_0001) begin
      n_fail++;
      $display("FAIL fill_head got v%b%b pc %h/%h inst %h/%h exp v11 pc 0000/0001", bus.out_valid0, bus.out_valid1,
               bus.out_pc0, bus.out_pc1, bus.out_inst0, bus.out_inst1);
    end
  endtask

  task automatic test_full_pop2();
    step(2'd2, 1'b0, '0);
    n_checks++; if (bus.count !== CW'(8)) begin n_fail++; $display("FAIL fullpop_count got %0d exp 8", bus.count); end
    n_checks++; if (bus.pc !== 16'h000A) begin n_fail++; $display("FAIL fullpop_pc got %h exp 000a", bus.pc); end
    n_checks++;
    if (bus.out_pc0 !== 16'h0002 || bus.out_pc1 !== 16'h0003 || bus.out_inst0 !== 32'hA5C3_0002) begin
      n_fail++;
      $display("FAIL fullpop_head got %h/%h inst %h exp 0002/0003", bus.out_pc0, bus.out_pc1, bus.out_inst0);
    end
  endtask

  task automatic test_drain_one();
    step(2'd0, 1'b1, 16'h0100);
    for (int i = 0; i < 24; i++) begin
      step(2'd1, 1'b0, '0);
      n_checks++; if (bus.count !== CW'(mq.size())) begin n_fail++; $display("FAIL drain_count cyc %0d got %0d exp %0d", i, bus.count, mq.size()); end
      n_checks++; if (bus.pc !== mpc) begin n_fail++; $display("FAIL drain_pc cyc %0d got %h exp %h", i, bus.pc, mpc); end
      n_checks++; if (bus.out_valid0 !== (mq.size() >= 1) || bus.out_valid1 !== (mq.size() >= 2)) begin n_fail++; $display("FAIL drain_valid cyc %0d got %b%b", i, bus.out_valid0, bus.out_valid1); end
      if (mq.size() >= 1) begin
        n_checks++; if (bus.out_pc0 !== mq[0].addr || bus.out_inst0 !== mq[0].inst) begin n_fail++; $display("FAIL drain_head0 cyc %0d got %h/%h exp %h/%h", i, bus.out_pc0, bus.out_inst0, mq[0].addr, mq[0].inst); end
      end
      if (mq.size() >= 2) begin
        n_checks++; if (bus.out_pc1 !== mq[1].addr || bus.out_inst1 !== mq[1].inst) begin n_fail++; $display("FAIL drain_head1 cyc %0d got %h/%h exp %h/%h", i, bus.out_pc1, bus.out_inst1, mq[1].addr, mq[1].inst); end
      end
    end
  endtask

  task automatic test_redirect();
    int guard;
    step(2'd0, 1'b1, 16'h0200);
    guard = 0;
    while (mq.size() != 5 && guard < 10) begin
      step((mq.size() == 0) ? 2'd0 : 2'd1, 1'b0, '0);
      guard++;
    end
    n_checks++; if (bus.count !== CW'(5)) begin n_fail++; $display("FAIL redir_setup_count got %0d exp 5", bus.count); end
    step(2'd2, 1'b1, 16'h0040);
    n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL redir_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.out_valid0 !== 1'b0 || bus.out_valid1 !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b%b exp 00", bus.out_valid0, bus.out_valid1); end
    n_checks++; if (bus.pc !== 16'h0040) begin n_fail++; $display("FAIL redir_pc got %h exp 0040", bus.pc); end
    step(2'd0, 1'b0, '0);
    n_checks++;
    if (bus.out_valid1 !== 1'b1 || bus.out_pc0 !== 16'h0040 || bus.out_pc1 !== 16'h0041 || bus.count !== CW'(2)) begin
      n_fail++;
      $display("FAIL redir_target got v1=%b pc %h/%h count %0d exp 1 0040/0041 2", bus.out_valid1, bus.out_pc0, bus.out_pc1, bus.count);
    end
  endtask

  task automatic test_pc_wrap();
    step(2'd0, 1'b1, 16'hFFFE);
    n_checks++; if (bus.pc !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_target got %h exp fffe", bus.pc); end
    step(2'd0, 1'b0, '0);
    n_checks++;
    if (bus.out_pc0 !== 16'hFFFE || bus.out_pc1 !== 16'hFFFF || bus.pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_pair1 got %h/%h pc %h exp fffe/ffff pc 0000", bus.out_pc0, bus.out_pc1, bus.pc);
    end
    step(2'd2, 1'b0, '0);
    n_checks++;
    if (bus.out_pc0 !== 16'h0000 || bus.out_pc1 !== 16'h0001 || bus.pc !== 16'h0002 || bus.count !== CW'(2)) begin
      n_fail++;
      $display("FAIL wrap_pair2 got %h/%h pc %h count %0d exp 0000/0001 pc 0002 count 2", bus.out_pc0, bus.out_pc1, bus.pc, bus.count);
    end
  endtask

  task automatic test_random();
    logic [1:0] ic;
    logic       bt;
    addr_t      tgt;
    for (int i = 0; i < 400; i++) begin
      ic  = 2'($urandom_range(0, 3));
      bt  = ($urandom_range(0, 15) == 0);
      tgt = 16'($urandom);
      step(ic, bt, tgt);
      n_checks++; if (bus.count !== CW'(mq.size())) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d exp %0d", i, bus.count, mq.size()); end
      n_checks++; if (bus.pc !== mpc) begin n_fail++; $display("FAIL rand_pc cyc %0d got %h exp %h", i, bus.pc, mpc); end
      n_checks++; if (bus.out_valid0 !== (mq.size() >= 1) || bus.out_valid1 !== (mq.size() >= 2)) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b%b", i, bus.out_valid0, bus.out_valid1); end
      if (mq.size() >= 1) begin
        n_checks++; if (bus.out_pc0 !== mq[0].addr || bus.out_inst0 !== mq[0].inst) begin n_fail++; $display("FAIL rand_head0 cyc %0d got %h/%h exp %h/%h", i, bus.out_pc0, bus.out_inst0, mq[0].addr, mq[0].inst); end
      end
      if (mq.size() >= 2) begin
        n_checks++; if (bus.out_pc1 !== mq[1].addr || bus.out_inst1 !== mq[1].inst) begin n_fail++; $display("FAIL rand_head1 cyc %0d got %h/%h exp %h/%h", i, bus.out_pc1, bus.out_inst1, mq[1].addr, mq[1].inst); end
      end
    end
  endtask

  task automatic test_async_reset();
    step(2'd0, 1'b1, 16'h0300);
    repeat (3) step(2'd0, 1'b0, '0);
    n_checks++; if (bus.count !== CW'(6)) begin n_fail++; $display("FAIL areset_setup got %0d exp 6", bus.count); end
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL areset_count got %0d exp 0", bus.count); end
    n_checks++; if (bus.out_valid0 !== 1'b0 || bus.out_valid1 !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b%b exp 00", bus.out_valid0, bus.out_valid1); end
    n_checks++; if (bus.pc !== RESET_PC) begin n_fail++; $display("FAIL areset_pc got %h exp %h", bus.pc, RESET_PC); end
    mq.delete();
    mpc = RESET_PC;
    @(negedge clk);
    reset = 1'b1;
    step(2'd0, 1'b0, '0);
    n_checks++;
    if (bus.count !== CW'(2) || bus.pc !== 16'h0002 || bus.out_pc0 !== 16'h0000 || bus.out_pc1 !== 16'h0001) begin
      n_fail++;
      $display("FAIL areset_restart got count %0d pc %h head %h/%h exp 2 0002 0000/0001", bus.count, bus.pc, bus.out_pc0, bus.out_pc1);
    end
  endtask

  initial begin
    test_reset();
    test_fill_idle();
    test_full_pop2();
    test_drain_one();
    test_redirect();
    test_pc_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
